serial_cmd_master: RTL
======================

Name: serial_cmd_master

Overview:
Host-side end of the 5-byte command / 4-byte reply serial protocol used by the SRAM-driver board.
- Accepts one command (cmd byte + 32-bit argument) from local logic and serialises it as 5 bytes through a uart_tx-style byte transmitter.
- Collects the 4-byte reply from a uart_rx-style byte receiver and presents it as one 32-bit word, with timeout reporting.
- Used by a bench/controller FPGA to drive ADDR/LOAD/WRITE/READ/READ_REQ/COUNT on the target.

Parameters:
TIMEOUT_CYCLES, 100000, inter-byte reply timeout in clk cycles; must be >= 1
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of timeout counter (derived, not overridden)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  command request
req_ready  output  1  block idle, can accept a request
req_cmd  input  8  command byte
req_arg  input  32  argument, sent MSB first
resp_valid  output  1  one-cycle pulse: reply complete or timed out
resp_data  output  32  reply word, first received byte most significant
resp_timeout  output  1  qualifies resp_valid: 1 = reply incomplete
tx_start  output  1  byte transmit strobe to UART TX
tx_data  output  8  byte to transmit
tx_ready  input  1  UART TX idle; falls 1-2 cycles after tx_start
rx_strobe  input  1  one-cycle pulse: rx_data valid
rx_data  input  8  received byte

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All state updates on posedge clk.
- Reset values: state IDLE, tx_start 0, tx_data 0, resp_valid 0, resp_data 0, resp_timeout 0; internal byte counters and timeout counter 0. req_ready = (state==IDLE) && !reset.
- States: IDLE, TX_LOAD, TX_WAIT_LOW, TX_WAIT_HIGH, RX, DONE.
- IDLE:
  - On req_valid && req_ready, latch {req_cmd, req_arg} into a 40-bit shift register, set tx_cnt=5 and go to TX_LOAD.
  - rx_strobe is ignored (stray bytes are discarded).
- TX_LOAD: when tx_ready=1, drive tx_data = shreg[39:32] and tx_start=1, then go to TX_WAIT_LOW.
- TX_WAIT_LOW:
  - Hold tx_start=1 and tx_data stable.
  - On a registered falling edge of tx_ready (prev=1, now=0): tx_start<=0, shreg<<=8, tx_cnt-=1, then go to TX_WAIT_HIGH.
- TX_WAIT_HIGH:
  - When tx_ready=1: if tx_cnt==0, clear rx_cnt, resp shift reg and timeout counter, then go to RX; otherwise go to TX_LOAD.
  - Byte order on the line is cmd, arg[31:24], arg[23:16], arg[15:8], arg[7:0].
- RX:
  - Each rx_strobe: resp_shift <= {resp_shift[23:0], rx_data}, rx_cnt+=1, timeout counter cleared.
  - When the 4th byte arrives, go to DONE with timeout flag 0.
  - With no strobe, the counter increments. On reaching TIMEOUT_CYCLES, go to DONE with timeout flag 1.
  - Partial bytes stay right-aligned; 0 bytes received gives 0x00000000.
- DONE (one cycle): resp_valid=1, resp_data=resp_shift, resp_timeout=flag, then go to IDLE.
- resp_data and resp_timeout hold their value until the next DONE.
- rx_strobe during TX states is discarded and does not count toward the reply.
- rx_strobe coinciding with the timeout-limit cycle counts as a byte: the byte wins and the counter clears.
- req_valid outside IDLE is ignored; there is no queuing.
- Reset in any state aborts the operation: tx_start drops the same cycle, and any partial reply is discarded with no resp_valid.
- Latency, request to first tx_start: 2 cycles, provided tx_ready=1.
- Latency, 4th rx_strobe to resp_valid: 1 cycle.
- Timeout resolution: exactly TIMEOUT_CYCLES cycles after the last byte event, ±1.

Test Plan:
- req cmd=0x01 arg=0x00001234, TX model with 2-cycle ready drop and 20-cycle busy; RX model echoes 00 00 12 34 -> tx bytes 01,00,00,12,34 in order, exactly one tx_start assertion per byte; resp_valid once, resp_data=0x00001234, resp_timeout=0.
- TIMEOUT_CYCLES=50, cmd=0x06, RX silent -> resp_valid exactly 50(±1) cycles after last tx byte completes; resp_data=0x00000000, resp_timeout=1.
- TIMEOUT_CYCLES=50, reply AB,CD with 10 cycles between them, then silence -> resp_data=0x0000ABCD, resp_timeout=1, 50 cycles after the CD strobe.
- Stray rx_strobe 0xFF in IDLE and mid-TX, then reply DE,AD,BE,EF -> resp_data=0xDEADBEEF, timeout 0.
- Second req_valid pulse while in RX -> req_ready=0, no extra tx bytes, first reply is delivered unchanged.
- reset asserted after 2nd byte sent -> next cycle tx_start=0, req_ready=1, no resp_valid; a new cmd=0x04 then completes normally with reply 00,00,00,5A -> 0x0000005A.

Source files
------------

// File: rtl/serial_cmd_master.sv
// Host-side master for the 5-byte command / 4-byte reply serial protocol.
// Sends cmd + 32-bit argument MSB first, then collects a 4-byte reply with inter-byte timeout.
module serial_cmd_master #(
   parameter  int TIMEOUT_CYCLES = 100000,
   localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_cmd,
   input  logic [31:0] req_arg,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_timeout,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_strobe,
   input  logic [7:0]  rx_data
);

   typedef enum logic [2:0] {
      IDLE,
      TX_LOAD,
      TX_WAIT_LOW,
      TX_WAIT_HIGH,
      RX,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state;
   logic [39:0]      r_shreg;
   logic [2:0]       r_tx_cnt;
   logic [2:0]       r_rx_cnt;
   logic [31:0]      r_resp_shift;
   logic [CNT_W-1:0] r_to_cnt;
   logic             r_tx_ready_d;
   logic             r_tx_start;
   logic [7:0]       r_tx_data;
   logic             r_resp_valid;
   logic [31:0]      r_resp_data;
   logic             r_resp_timeout;
   logic             w_tx_fall;

   assign w_tx_fall    = r_tx_ready_d && !tx_ready;
   assign req_ready    = (r_state == IDLE) && !reset;
   assign tx_start     = r_tx_start;
   assign tx_data      = r_tx_data;
   assign resp_valid   = r_resp_valid;
   assign resp_data    = r_resp_data;
   assign resp_timeout = r_resp_timeout;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_shreg        <= '0;
         r_tx_cnt       <= '0;
         r_rx_cnt       <= '0;
         r_resp_shift   <= '0;
         r_to_cnt       <= '0;
         r_tx_ready_d   <= 1'b0;
         r_tx_start     <= 1'b0;
         r_tx_data      <= '0;
         r_resp_valid   <= 1'b0;
         r_resp_data    <= '0;
         r_resp_timeout <= 1'b0;
      end else begin
         r_tx_ready_d <= tx_ready;
         case (r_state)
            IDLE: begin
               r_resp_valid <= 1'b0;
               if (req_valid) begin
                  r_shreg  <= {req_cmd, req_arg};
                  r_tx_cnt <= 3'd5;
                  r_state  <= TX_LOAD;
               end
            end
            TX_LOAD: begin
               if (tx_ready) begin
                  r_tx_data  <= r_shreg[39:32];
                  r_tx_start <= 1'b1;
                  r_state    <= TX_WAIT_LOW;
               end
            end
            TX_WAIT_LOW: begin
               // The transmitter acknowledges a byte by dropping ready.
               if (w_tx_fall) begin
                  r_tx_start <= 1'b0;
                  r_shreg    <= {r_shreg[31:0], 8'h00};
                  r_tx_cnt   <= r_tx_cnt - 3'd1;
                  r_state    <= TX_WAIT_HIGH;
               end
            end
            TX_WAIT_HIGH: begin
               if (tx_ready) begin
                  if (r_tx_cnt == 3'd0) begin
                     r_rx_cnt     <= '0;
                     r_resp_shift <= '0;
                     r_to_cnt     <= '0;
                     r_state      <= RX;
                  end else begin
                     r_state <= TX_LOAD;
                  end
               end
            end
            RX: begin
               // A byte arriving on the limit cycle takes priority over the timeout.
               if (rx_strobe) begin
                  r_resp_shift <= {r_resp_shift[23:0], rx_data};
                  r_rx_cnt     <= r_rx_cnt + 3'd1;
                  r_to_cnt     <= '0;
                  if (r_rx_cnt == 3'd3) begin
                     r_resp_valid   <= 1'b1;
                     r_resp_data    <= {r_resp_shift[23:0], rx_data};
                     r_resp_timeout <= 1'b0;
                     r_state        <= DONE;
                  end
               end else if (r_to_cnt == TO_LAST) begin
                  r_resp_valid   <= 1'b1;
                  r_resp_data    <= r_resp_shift;
                  r_resp_timeout <= 1'b1;
                  r_state        <= DONE;
               end else begin
                  r_to_cnt <= r_to_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               r_resp_valid <= 1'b0;
               r_state      <= IDLE;
            end
            default: begin
               r_tx_start   <= 1'b0;
               r_resp_valid <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

endmodule
